// File: rtl/rr_arbiter_4x1_4b_pkg.sv
// Shared definitions for the 4-way round-robin display arbiter.
// Holds the state encoding, the default parameters and a one-hot helper.
package rr_arbiter_4x1_4b_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned HOLD_DEF  = 4;
    localparam int unsigned NUM_REQ   = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] vec;
        vec = 4'b0000;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/rr_arbiter_4x1_4b_pick4.sv
// Combinational round-robin picker: scans requesters starting one past the
// last winner and returns the first one found.
module rr_pick4
    import rr_arbiter_4x1_4b_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] grant,
    output logic       any_req
);

    logic       found_s;
    logic [1:0] idx_s;

    // rotating priority scan, lowest priority goes to the previous winner
    always_comb begin
        grant   = 2'd0;
        found_s = 1'b0;
        idx_s   = 2'd0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx_s = last + 2'(i);
            if (!found_s && req[idx_s]) begin
                grant   = idx_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_arbiter_4x1_4b.sv
// Round-robin scheduler sharing one display channel between four requesters;
// holds each winner's captured data for HOLD cycles and ACKs at slot end.
module rr_arbiter_4x1_4b
    import rr_arbiter_4x1_4b_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned HOLD  = HOLD_DEF
) (
    input  logic             CLK_i,
    input  logic             RST_i,
    input  logic [3:0]       REQ_i,
    input  logic [WIDTH-1:0] ENT0_i,
    input  logic [WIDTH-1:0] ENT1_i,
    input  logic [WIDTH-1:0] ENT2_i,
    input  logic [WIDTH-1:0] ENT3_i,
    output logic [1:0]       SEL_o,
    output logic [WIDTH-1:0] output_o,
    output logic             VALID_o,
    output logic [3:0]       ACK_o,
    output logic             BUSY_o
);

    localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

    state_t           state_r, state_s;
    logic [7:0]       cnt_r, cnt_s;
    logic [1:0]       last_r, last_s;
    logic [1:0]       sel_s;
    logic [WIDTH-1:0] data_s;
    logic             valid_s;
    logic [3:0]       ack_s;
    logic             busy_s;
    logic [1:0]       pick_s;
    logic             any_req_s;
    logic [WIDTH-1:0] ent_pick_s;

    rr_pick4 u_pick (
        .req     (REQ_i),
        .last    (last_r),
        .grant   (pick_s),
        .any_req (any_req_s)
    );

    // data of the candidate winner, captured only on the grant edge
    always_comb begin
        case (pick_s)
            2'd0:    ent_pick_s = ENT0_i;
            2'd1:    ent_pick_s = ENT1_i;
            2'd2:    ent_pick_s = ENT2_i;
            2'd3:    ent_pick_s = ENT3_i;
            default: ent_pick_s = ENT0_i;
        endcase
    end

    // next-state and next-output logic for the slot FSM
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        last_s  = last_r;
        sel_s   = SEL_o;
        data_s  = output_o;
        valid_s = VALID_o;
        ack_s   = 4'b0000;
        busy_s  = BUSY_o;
        case (state_r)
            ST_IDLE: begin
                valid_s = 1'b0;
                busy_s  = 1'b0;
                if (any_req_s) begin
                    state_s = ST_HOLD;
                    cnt_s   = HOLD_M1;
                    last_s  = pick_s;
                    sel_s   = pick_s;
                    data_s  = ent_pick_s;
                    valid_s = 1'b1;
                    busy_s  = 1'b1;
                    // a one-cycle slot carries its ACK on the grant cycle
                    if (HOLD_M1 == 8'd0) begin
                        ack_s = onehot4(pick_s);
                    end else begin
                        ack_s = 4'b0000;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (cnt_r != 8'd0) begin
                    cnt_s = cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        ack_s = onehot4(last_r);
                    end else begin
                        ack_s = 4'b0000;
                    end
                end else begin
                    state_s = ST_IDLE;
                    valid_s = 1'b0;
                    busy_s  = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 8'd0;
                valid_s = 1'b0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // state, counter and output registers
    always_ff @(posedge CLK_i or posedge RST_i) begin
        if (RST_i) begin
            state_r  <= ST_IDLE;
            cnt_r    <= 8'd0;
            last_r   <= 2'd3;
            SEL_o    <= 2'd0;
            output_o <= '0;
            VALID_o  <= 1'b0;
            ACK_o    <= 4'b0000;
            BUSY_o   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            last_r   <= last_s;
            SEL_o    <= sel_s;
            output_o <= data_s;
            VALID_o  <= valid_s;
            ACK_o    <= ack_s;
            BUSY_o   <= busy_s;
        end
    end

endmodule
